// File: rtl/pipe_share_arbiter.sv
// Round-robin front end sharing one fixed-latency, non-stallable pipeline between NUM_REQ requesters.
// Requester IDs ride a tag delay line matched to the pipeline latency so each result returns to its issuer.
module pipe_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int LATENCY = 2
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_REQ-1:0]                 req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]           req_data,
    output logic [NUM_REQ-1:0]                 req_ready,
    output logic                               pipe_input_valid,
    output logic [WIDTH-1:0]                   pipe_x,
    input  logic                               pipe_output_valid,
    input  logic [WIDTH-1:0]                   pipe_out,
    output logic [NUM_REQ-1:0]                 rsp_valid,
    output logic [WIDTH-1:0]                   rsp_data,
    output logic [$clog2(LATENCY+1)-1:0]       in_flight,
    output logic                               tag_err
);
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int IFW   = $clog2(LATENCY+1);

    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [NUM_REQ-1:0] req_act;
    logic [PTR_W-1:0]   grant_id;
    logic               any_req;
    int                 idx;

    logic [LATENCY-1:0] tag_valid_q;
    logic [PTR_W-1:0]   tag_id_q [LATENCY];
    logic               tag_last_v;
    logic               ret;
    logic [IFW-1:0]     in_flight_q, in_flight_d;
    logic               tag_err_q, tag_err_d;

    // Requests are ignored while reset is held so nothing is granted or issued.
    assign req_act = rst_n ? req_valid : '0;

    always_comb begin
        any_req  = 1'b0;
        grant_id = '0;
        idx      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr_q) + k) % NUM_REQ;
            if (!any_req && req_act[idx]) begin
                any_req  = 1'b1;
                grant_id = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        req_ready        = '0;
        pipe_input_valid = any_req;
        pipe_x           = '0;
        ptr_d            = ptr_q;
        if (any_req) begin
            req_ready = NUM_REQ'(1) << grant_id;
            pipe_x    = req_data[grant_id*WIDTH +: WIDTH];
            ptr_d     = (int'(grant_id) == NUM_REQ-1) ? '0 : PTR_W'(int'(grant_id) + 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            tag_valid_q <= '0;
            for (int s = 0; s < LATENCY; s++) tag_id_q[s] <= '0;
            in_flight_q <= '0;
            tag_err_q   <= 1'b0;
        end else begin
            ptr_q          <= ptr_d;
            tag_valid_q[0] <= pipe_input_valid;
            tag_id_q[0]    <= grant_id;
            for (int s = 1; s < LATENCY; s++) begin
                tag_valid_q[s] <= tag_valid_q[s-1];
                tag_id_q[s]    <= tag_id_q[s-1];
            end
            in_flight_q <= in_flight_d;
            tag_err_q   <= tag_err_d;
        end
    end

    assign tag_last_v = tag_valid_q[LATENCY-1];
    assign ret        = tag_last_v & pipe_output_valid;

    // in_flight tracks tags leaving the line, so it always equals the number of valid tags.
    always_comb begin
        in_flight_d = in_flight_q;
        case ({pipe_input_valid, tag_last_v})
            2'b10:   in_flight_d = in_flight_q + IFW'(1);
            2'b01:   in_flight_d = in_flight_q - IFW'(1);
            default: in_flight_d = in_flight_q;
        endcase
        tag_err_d = tag_err_q | (tag_last_v ^ pipe_output_valid);
    end

    always_comb begin
        rsp_valid = '0;
        if (ret) rsp_valid = NUM_REQ'(1) << tag_id_q[LATENCY-1];
    end

    assign rsp_data  = pipe_out;
    assign in_flight = in_flight_q;
    assign tag_err   = tag_err_q;
endmodule
